// File: rtl/charlie7x5_pkg.sv
// Shared constants for the charlieplexed 7-pin / 5x7 LED matrix Wishbone slave.
// The cathode helper is the single definition of the LED-to-pin pairing.
package charlie7x5_pkg;

   localparam int unsigned NUM_PINS = 7;
   localparam int unsigned NUM_COLS = 5;

   localparam logic [2:0] ADR_COL0  = 3'd0;
   localparam logic [2:0] ADR_COL1  = 3'd1;
   localparam logic [2:0] ADR_COL2  = 3'd2;
   localparam logic [2:0] ADR_COL3  = 3'd3;
   localparam logic [2:0] ADR_COL4  = 3'd4;
   localparam logic [2:0] ADR_CTRL  = 3'd5;
   localparam logic [2:0] ADR_FRAME = 3'd6;

   localparam int unsigned CTRL_EN   = 0;
   localparam int unsigned CTRL_SWAP = 1;

   localparam logic PH_BLANK = 1'b0;
   localparam logic PH_LIT   = 1'b1;

   // Cathode pin for LED (col, row) is (row + col + 1) mod 7; row <= 6, col <= 4.
   function automatic logic [2:0] cathode_pin(input logic [2:0] row, input logic [2:0] col);
      logic [3:0] s;
      s = {1'b0, row} + {1'b0, col} + 4'd1;
      return (s >= 4'd7) ? 3'(s - 4'd7) : s[2:0];
   endfunction

endpackage

// File: rtl/charlie7x5_pinmap.sv
// Combinational row decoder: anode pin of the row driven high, cathodes of lit
// LEDs in that row driven low, every other pin tri-stated.
module charlie7x5_pinmap
   import charlie7x5_pkg::*;
(
   input  logic [2:0]          row,
   input  logic [NUM_COLS-1:0] col_bits,
   output logic [NUM_PINS-1:0] o,
   output logic [NUM_PINS-1:0] oe
);

   always_comb begin
      o  = '0;
      oe = '0;
      if (row < 3'(NUM_PINS)) begin
         o[row]  = 1'b1;
         oe[row] = 1'b1;
         for (int c = 0; c < NUM_COLS; c++) begin
            if (col_bits[c]) oe[cathode_pin(row, 3'(c))] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/charlie7x5_wb.sv
// Wishbone-classic slave holding a double-buffered 5x7 framebuffer and scanning
// the active buffer row by row onto a 7-pin charlieplexed LED matrix.
module charlie7x5_wb
   import charlie7x5_pkg::*;
#(
   parameter int unsigned TICKS_PER_ROW = 1024,
   parameter int unsigned BLANK_TICKS   = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wb_cyc,
   input  logic                wb_stb,
   input  logic                wb_we,
   input  logic [2:0]          wb_adr,
   input  logic [7:0]          wb_dat_i,
   output logic [7:0]          wb_dat_o,
   output logic                wb_ack,
   output logic [NUM_PINS-1:0] charlie7x5_o,
   output logic [NUM_PINS-1:0] charlie7x5_oe
);

   localparam int unsigned MAX_TICKS =
      (TICKS_PER_ROW > BLANK_TICKS) ? TICKS_PER_ROW : BLANK_TICKS;
   localparam int unsigned TICK_W = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
   localparam logic [TICK_W-1:0] LIT_LAST   = TICK_W'(TICKS_PER_ROW - 1);
   localparam logic [TICK_W-1:0] BLANK_LAST = TICK_W'(BLANK_TICKS - 1);

   logic [NUM_COLS-1:0][NUM_PINS-1:0] back_q, back_d, active_q, active_d;
   logic                enable_q, enable_d, pending_q, pending_d;
   logic [7:0]          frame_q, frame_d;
   logic [2:0]          row_q, row_d;
   logic                phase_q, phase_d;
   logic [TICK_W-1:0]   tick_q, tick_d;
   logic                ack_q, ack_d;
   logic [7:0]          dat_q, dat_d, rd_data;
   logic [NUM_PINS-1:0] pin_o_q, pin_o_d, pin_oe_q, pin_oe_d, map_o, map_oe;
   logic [NUM_COLS-1:0] col_slice;
   logic                frame_end, req, wr_en;

   always_comb begin
      row_d     = row_q;
      phase_d   = phase_q;
      tick_d    = tick_q + 1'b1;
      frame_end = 1'b0;
      if (phase_q == PH_BLANK) begin
         if (tick_q == BLANK_LAST) begin
            phase_d = PH_LIT;
            tick_d  = '0;
         end
      end else if (tick_q == LIT_LAST) begin
         phase_d = PH_BLANK;
         tick_d  = '0;
         if (row_q == 3'd6) begin
            row_d     = 3'd0;
            frame_end = 1'b1;
         end else begin
            row_d = row_q + 3'd1;
         end
      end
   end

   always_comb begin
      for (int c = 0; c < NUM_COLS; c++) col_slice[c] = active_q[c][row_q];
   end

   charlie7x5_pinmap u_pinmap (
      .row      (row_q),
      .col_bits (col_slice),
      .o        (map_o),
      .oe       (map_oe)
   );

   always_comb begin
      pin_o_d  = '0;
      pin_oe_d = '0;
      if (phase_q == PH_LIT && enable_q) begin
         pin_o_d  = map_o;
         pin_oe_d = map_oe;
      end
   end

   assign req   = wb_cyc & wb_stb & ~ack_q;
   assign wr_en = req & wb_we;
   assign ack_d = req;

   always_comb begin
      rd_data = '0;
      if (wb_adr <= ADR_COL4)        rd_data = {1'b0, back_q[wb_adr]};
      else if (wb_adr == ADR_CTRL)   rd_data = {6'b0, pending_q, enable_q};
      else if (wb_adr == ADR_FRAME)  rd_data = frame_q;
      dat_d = (req && !wb_we) ? rd_data : 8'h00;
   end

   // Swap and pending clear use pre-write values; a swap-request write wins over the clear.
   always_comb begin
      back_d    = back_q;
      enable_d  = enable_q;
      pending_d = pending_q;
      active_d  = active_q;
      frame_d   = frame_q;
      if (frame_end) begin
         frame_d   = frame_q + 8'd1;
         pending_d = 1'b0;
         if (pending_q) active_d = back_q;
      end
      if (wr_en) begin
         if (wb_adr <= ADR_COL4) back_d[wb_adr] = wb_dat_i[NUM_PINS-1:0];
         if (wb_adr == ADR_CTRL) begin
            enable_d = wb_dat_i[CTRL_EN];
            if (wb_dat_i[CTRL_SWAP]) pending_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         back_q    <= '0;
         active_q  <= '0;
         enable_q  <= 1'b0;
         pending_q <= 1'b0;
         frame_q   <= '0;
         row_q     <= '0;
         phase_q   <= PH_BLANK;
         tick_q    <= '0;
         ack_q     <= 1'b0;
         dat_q     <= '0;
         pin_o_q   <= '0;
         pin_oe_q  <= '0;
      end else begin
         back_q    <= back_d;
         active_q  <= active_d;
         enable_q  <= enable_d;
         pending_q <= pending_d;
         frame_q   <= frame_d;
         row_q     <= row_d;
         phase_q   <= phase_d;
         tick_q    <= tick_d;
         ack_q     <= ack_d;
         dat_q     <= dat_d;
         pin_o_q   <= pin_o_d;
         pin_oe_q  <= pin_oe_d;
      end
   end

   assign wb_ack        = ack_q;
   assign wb_dat_o      = dat_q;
   assign charlie7x5_o  = pin_o_q;
   assign charlie7x5_oe = pin_oe_q;

endmodule

// File: tb/tb_charlie7x5_wb.sv
// Randomized bench for charlie7x5_wb against a cycle-count based reference model.
module tb_charlie7x5_wb;

   localparam int TPR     = 4;
   localparam int BT      = 1;
   localparam int ROW_LEN = TPR + BT;
   localparam int FRAME   = 7 * ROW_LEN;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
   logic [2:0] wb_adr = '0;
   logic [7:0] wb_dat_i = '0;
   logic [7:0] wb_dat_o;
   logic       wb_ack;
   logic [6:0] charlie7x5_o, charlie7x5_oe;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   charlie7x5_wb #(.TICKS_PER_ROW(TPR), .BLANK_TICKS(BT)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wb_cyc        (wb_cyc),
      .wb_stb        (wb_stb),
      .wb_we         (wb_we),
      .wb_adr        (wb_adr),
      .wb_dat_i      (wb_dat_i),
      .wb_dat_o      (wb_dat_o),
      .wb_ack        (wb_ack),
      .charlie7x5_o  (charlie7x5_o),
      .charlie7x5_oe (charlie7x5_oe)
   );

   // Reference model: scan position is derived purely from clock count since reset.
   int unsigned      m_n = 0;
   logic [4:0][6:0]  m_back = '0, m_active = '0;
   logic             m_en = 1'b0, m_pend = 1'b0, m_ack = 1'b0;
   logic [7:0]       m_frame = '0, m_rd = '0;
   logic [6:0]       m_o = '0, m_oe = '0;
   logic             m_bnd, m_req, m_wr;

   assign m_bnd = ((m_n + 1) % FRAME) == 0;
   assign m_req = wb_cyc && wb_stb && !m_ack;
   assign m_wr  = m_req && wb_we;

   function automatic logic [13:0] model_pins(int unsigned n, logic en, logic [4:0][6:0] act);
      int unsigned pos = n % FRAME;
      int unsigned row = pos / ROW_LEN;
      logic [6:0] o = '0, oe = '0;
      if (en && (pos % ROW_LEN) != 0) begin
         o[row]  = 1'b1;
         oe[row] = 1'b1;
         for (int c = 0; c < 5; c++) if (act[c][row]) oe[(row + c + 1) % 7] = 1'b1;
      end
      return {o, oe};
   endfunction

   function automatic logic [7:0] model_read(logic [2:0] a);
      if (a < 3'd5) return {1'b0, m_back[a]};
      if (a == 3'd5) return {6'b0, m_pend, m_en};
      if (a == 3'd6) return m_frame;
      return 8'h00;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_n <= 0; m_back <= '0; m_active <= '0; m_en <= 1'b0; m_pend <= 1'b0;
         m_frame <= '0; m_ack <= 1'b0; m_rd <= '0; m_o <= '0; m_oe <= '0;
      end else begin
         m_n <= m_n + 1;
         {m_o, m_oe} <= model_pins(m_n, m_en, m_active);
         m_ack <= m_req;
         m_rd  <= (m_req && !wb_we) ? model_read(wb_adr) : 8'h00;
         if (m_bnd) begin
            m_frame <= m_frame + 8'd1;
            if (m_pend) m_active <= m_back;
         end
         if (m_wr && wb_adr == 3'd5 && wb_dat_i[1]) m_pend <= 1'b1;
         else if (m_bnd) m_pend <= 1'b0;
         if (m_wr && wb_adr < 3'd5) m_back[wb_adr] <= wb_dat_i[6:0];
         if (m_wr && wb_adr == 3'd5) m_en <= wb_dat_i[0];
      end
   end

   // One Wishbone access; returns DUT ack/data and the model's expected read data.
   task automatic bus(input logic we, input logic [2:0] adr, input logic [7:0] dat,
                      output logic ack, output logic [7:0] rd, output logic [7:0] exp_rd);
      @(negedge clk);
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = dat;
      @(negedge clk);
      ack = wb_ack; rd = wb_dat_o; exp_rd = m_rd;
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
   endtask

   task automatic scan_check(input int cycles, input string tag);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         total++;
         if (charlie7x5_o !== m_o || charlie7x5_oe !== m_oe) begin
            bad++;
            $display("FAIL %s pins n=%0d: got o=%b oe=%b want o=%b oe=%b",
                     tag, m_n, charlie7x5_o, charlie7x5_oe, m_o, m_oe);
         end
      end
   endtask

   task automatic test_reset();
      logic ack; logic [7:0] rd, erd; logic got [4];
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (wb_ack !== 1'b0 || wb_dat_o !== 8'h00) begin
         bad++; $display("FAIL reset_bus: got ack=%b dat=%h want 0/00", wb_ack, wb_dat_o);
      end
      total++;
      if (charlie7x5_o !== 7'h00 || charlie7x5_oe !== 7'h00) begin
         bad++; $display("FAIL reset_pins: got o=%b oe=%b want 0", charlie7x5_o, charlie7x5_oe);
      end
      rst_n = 1'b1;
      bus(1'b0, 3'd5, 8'h00, ack, rd, erd);
      total++;
      if (ack !== 1'b1 || rd !== 8'h00) begin
         bad++; $display("FAIL reset_ctrl_read: got ack=%b dat=%h want 1/00", ack, rd);
      end
      @(negedge clk);
      total++;
      if (wb_ack !== 1'b0 || wb_dat_o !== 8'h00) begin
         bad++; $display("FAIL ack_single: got ack=%b dat=%h want 0/00", wb_ack, wb_dat_o);
      end
      bus(1'b0, 3'd6, 8'h00, ack, rd, erd);
      total++;
      if (ack !== 1'b1 || rd !== 8'h00) begin
         bad++; $display("FAIL reset_frame_read: got ack=%b dat=%h want 1/00", ack, rd);
      end
      // Strobe held for four edges: ack must alternate 1,0,1,0.
      @(negedge clk);
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 3'd5;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         got[i] = wb_ack;
      end
      wb_cyc = 1'b0; wb_stb = 1'b0;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (got[i] !== ((i % 2) == 0)) begin
            bad++; $display("FAIL back_to_back[%0d]: got ack=%b want %b", i, got[i], (i % 2) == 0);
         end
      end
   endtask

   task automatic test_single_pixel();
      logic ack; logic [7:0] rd, erd; int pos, row;
      bus(1'b1, 3'd0, 8'h01, ack, rd, erd);
      bus(1'b1, 3'd5, 8'h03, ack, rd, erd);
      scan_check(FRAME + 1, "pixel_swap");
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         pos = int'((m_n - 1) % FRAME);
         row = pos / ROW_LEN;
         total++;
         if ((pos % ROW_LEN) == 0) begin
            if (charlie7x5_o !== 7'h00 || charlie7x5_oe !== 7'h00) begin
               bad++; $display("FAIL pixel_blank: got o=%b oe=%b want 0", charlie7x5_o, charlie7x5_oe);
            end
         end else if (row == 0) begin
            if (charlie7x5_o !== 7'b0000001 || charlie7x5_oe !== 7'b0000011) begin
               bad++; $display("FAIL pixel_row0: got o=%b oe=%b want 0000001/0000011",
                               charlie7x5_o, charlie7x5_oe);
            end
         end else if (charlie7x5_o !== 7'(1 << row) || charlie7x5_oe !== 7'(1 << row)) begin
            bad++; $display("FAIL pixel_row%0d: got o=%b oe=%b want %b", row,
                            charlie7x5_o, charlie7x5_oe, 7'(1 << row));
         end
      end
      bus(1'b0, 3'd5, 8'h00, ack, rd, erd);
      total++;
      if (rd !== 8'h01) begin
         bad++; $display("FAIL pixel_ctrl_read: got %h want 01", rd);
      end
   endtask

   task automatic test_all_ones();
      logic ack; logic [7:0] rd, erd; int pos, row;
      for (int c = 0; c < 5; c++) bus(1'b1, 3'(c), 8'hFF, ack, rd, erd);
      bus(1'b1, 3'd5, 8'h03, ack, rd, erd);
      scan_check(FRAME + 1, "ones_swap");
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         pos = int'((m_n - 1) % FRAME);
         row = pos / ROW_LEN;
         if ((pos % ROW_LEN) != 0) begin
            total++;
            if ($countones(charlie7x5_oe) != 6 || charlie7x5_o !== 7'(1 << row)) begin
               bad++; $display("FAIL ones_row%0d: got o=%b oe=%b want o=%b with 6 enables",
                               row, charlie7x5_o, charlie7x5_oe, 7'(1 << row));
            end
            if (row == 3) begin
               total++;
               if (charlie7x5_oe !== 7'b1111011) begin
                  bad++; $display("FAIL ones_row3_oe: got %b want 1111011", charlie7x5_oe);
               end
            end
         end
      end
   endtask

   task automatic test_no_swap();
      logic ack; logic [7:0] rd, erd, f0, f1;
      bus(1'b1, 3'd2, {1'b0, 7'($urandom)}, ack, rd, erd);
      bus(1'b1, 3'd5, 8'h01, ack, rd, erd);
      bus(1'b0, 3'd6, 8'h00, ack, f0, erd);
      total++;
      if (f0 !== erd) begin
         bad++; $display("FAIL frame_read0: got %h want %h", f0, erd);
      end
      scan_check(103, "no_swap");
      bus(1'b0, 3'd6, 8'h00, ack, f1, erd);
      total++;
      if (8'(f1 - f0) !== 8'd3) begin
         bad++; $display("FAIL frame_delta: got %0d want 3", 8'(f1 - f0));
      end
      bus(1'b0, 3'd5, 8'h00, ack, rd, erd);
      total++;
      if (rd !== 8'h01) begin
         bad++; $display("FAIL no_swap_ctrl: got %h want 01", rd);
      end
      bus(1'b1, 3'd5, 8'h03, ack, rd, erd);
      scan_check(2 * FRAME, "late_swap");
   endtask

   task automatic test_boundary();
      logic ack; logic [7:0] rd, erd; int guard;
      bus(1'b1, 3'd4, {1'b0, m_active[4] ^ 7'h55}, ack, rd, erd);
      guard = 0;
      while (((m_n + 2) % FRAME) != 0 && guard < 2 * FRAME) begin
         @(negedge clk);
         guard++;
      end
      total++;
      if (guard >= 2 * FRAME) begin
         bad++; $display("FAIL boundary_wait: got timeout want boundary alignment");
      end
      bus(1'b1, 3'd5, 8'h03, ack, rd, erd);
      bus(1'b0, 3'd5, 8'h00, ack, rd, erd);
      total++;
      if (rd !== 8'h03) begin
         bad++; $display("FAIL boundary_pending: got %h want 03", rd);
      end
      scan_check(FRAME, "boundary_hold");
      bus(1'b0, 3'd5, 8'h00, ack, rd, erd);
      total++;
      if (rd !== 8'h01) begin
         bad++; $display("FAIL boundary_cleared: got %h want 01", rd);
      end
      while (((m_n + 2) % FRAME) != 0) @(negedge clk);
      bus(1'b0, 3'd6, 8'h00, ack, rd, erd);
      total++;
      if (rd !== erd) begin
         bad++; $display("FAIL boundary_frame_read: got %h want %h", rd, erd);
      end
      scan_check(FRAME, "boundary_after");
   endtask

   task automatic test_random();
      logic ack; logic [7:0] rd, erd; logic we; logic [2:0] adr; logic [7:0] dat;
      for (int i = 0; i < 40; i++) begin
         we  = ($urandom_range(0, 9) < 5);
         adr = 3'($urandom_range(0, 7));
         dat = 8'($urandom);
         if (we && adr == 3'd5) dat[0] = ($urandom_range(0, 3) != 0);
         bus(we, adr, dat, ack, rd, erd);
         total++;
         if (ack !== 1'b1 || (!we && rd !== erd)) begin
            bad++; $display("FAIL random_bus[%0d] adr=%0d we=%b: got ack=%b dat=%h want 1/%h",
                            i, adr, we, ack, rd, erd);
         end
         scan_check($urandom_range(0, 12), "random");
      end
      scan_check(FRAME, "random_tail");
   endtask

   task automatic test_reset_mid();
      logic ack; logic [7:0] rd, erd; int guard;
      bus(1'b1, 3'd5, 8'h01, ack, rd, erd);
      guard = 0;
      while (m_o == 7'h00 && guard < 2 * FRAME) begin
         @(negedge clk);
         guard++;
      end
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 3'd6;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (charlie7x5_o !== 7'h00 || charlie7x5_oe !== 7'h00 || wb_ack !== 1'b0) begin
         bad++; $display("FAIL async_reset: got o=%b oe=%b ack=%b want 0",
                         charlie7x5_o, charlie7x5_oe, wb_ack);
      end
      @(negedge clk);
      total++;
      if (wb_ack !== 1'b0 || wb_dat_o !== 8'h00) begin
         bad++; $display("FAIL aborted_ack: got ack=%b dat=%h want 0/00", wb_ack, wb_dat_o);
      end
      wb_cyc = 1'b0; wb_stb = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      bus(1'b0, 3'd6, 8'h00, ack, rd, erd);
      total++;
      if (ack !== 1'b1 || rd !== 8'h00) begin
         bad++; $display("FAIL post_reset_frame: got ack=%b dat=%h want 1/00", ack, rd);
      end
      for (int c = 0; c < 5; c++) bus(1'b1, 3'(c), 8'($urandom), ack, rd, erd);
      bus(1'b1, 3'd5, 8'h03, ack, rd, erd);
      scan_check(2 * FRAME, "post_reset");
   endtask

   initial begin
      #1 rst_n = 1'b0;
      test_reset();
      test_single_pixel();
      test_all_ones();
      test_no_swap();
      test_boundary();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/charlie7x5_wb.md
Name: charlie7x5_wb

Overview:
- Wishbone-classic slave that holds a double-buffered 5-column x 7-row LED framebuffer.
- Continuously scans the framebuffer onto a 7-pin charlieplexed matrix through charlie7x5_o and charlie7x5_oe.
- Sits downstream of the SPI-to-Wishbone master inside top; its pin outputs drive the top-level charlie7x5 ports directly.

Parameters:
- TICKS_PER_ROW, 1024, clock cycles each row is lit (>=1).
- BLANK_TICKS, 16, clock cycles all pins are tri-stated before each row (>=1; suppresses ghosting).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- wb_cyc  input  1  bus cycle
- wb_stb  input  1  strobe
- wb_we  input  1  write enable
- wb_adr  input  3  register address
- wb_dat_i  input  8  write data
- wb_dat_o  output  8  read data
- wb_ack  output  1  acknowledge
- charlie7x5_o  output  7  pin drive levels
- charlie7x5_oe  output  7  pin output enables (0 = high-Z)

Behaviour:
- Reset (asynchronous, rst_n=0), all registers clear:
  - wb_ack=0, wb_dat_o=0, charlie7x5_o=0, charlie7x5_oe=0.
  - Back and active buffers all 0; enable=0; pending=0; frame_cnt=0.
  - Scan state = row 0, blank phase, tick counter 0.
  - Reset asserted mid-frame or mid-bus-cycle aborts everything immediately; no ack is issued for an aborted access.
- Register map (wb_adr):
  - 0-4: back-buffer column c, bits[6:0] = rows 0-6; bit7 writes ignored, reads 0.
  - 5: control. Write: bit0 = enable; bit1 = 1 sets pending (writing 0 to bit1 does not clear it). Read: {6'b0, pending, enable}.
  - 6: frame_cnt, read-only, 8-bit, wraps 255 -> 0. Writes ignored.
  - 7: reads 0, writes ignored.
- Wishbone handshake:
  - wb_ack is registered: wb_ack <= wb_cyc & wb_stb & ~wb_ack. This gives exactly one ack one cycle after the strobe and a gap cycle between back-to-back accesses.
  - A write takes effect on the cycle the ack is registered (the strobe cycle edge).
  - wb_dat_o is registered alongside the ack and is held at 0 when wb_ack=0.
  - Reads of 0-4 return the back buffer, not the active buffer.
- Scan sequencer, per row r = 0..6:
  - Blank phase: BLANK_TICKS cycles.
  - Lit phase: TICKS_PER_ROW cycles.
  - Frame length = 7*(BLANK_TICKS+TICKS_PER_ROW) cycles. Row 6 wraps to row 0.
  - The scan runs regardless of enable.
- Pin mapping:
  - The LED at (col c, row r) has its anode on pin r and its cathode on pin (r+c+1) mod 7. All 35 pairs are distinct and the cathode never equals the anode.
- Outputs, registered and lagging the scan state by one cycle:
  - Blank phase, or enable=0: o=0, oe=0.
  - Lit row r: o[r]=1, oe[r]=1. For each c with active[c][r]=1, pin k=(r+c+1) mod 7 gets oe[k]=1, o[k]=0.
  - All other pins: oe=0, o=0.
  - No pin other than r is ever driven high.
- Frame boundary = the cycle the sequencer moves from row 6 lit to row 0 blank. On that cycle:
  - frame_cnt increments.
  - If pending=1: active <= back and pending <= 0.
- Simultaneous events on a boundary cycle:
  - The swap samples pre-write values: a back-buffer write on that cycle is not copied into active.
  - A control write setting bit1 on that cycle leaves pending=1 for the next frame.
  - frame_cnt read on that cycle returns the pre-increment value.
- Toggling enable affects the outputs from the next cycle and does not disturb scan position.

Decomposition:
- Shared package charlie7x5_pkg:
  - NUM_PINS=7, NUM_COLS=5.
  - Register addresses ADR_COL0..ADR_COL4, ADR_CTRL, ADR_FRAME.
  - Control bit indices CTRL_EN=0, CTRL_SWAP=1.
- Sub-module charlie7x5_pinmap: purely combinational. Inputs row[2:0] and a 5-bit column-slice of active for that row; outputs the next o/oe vectors. Isolated so the mapping is unit-checkable exhaustively.

Test Plan (bench uses TICKS_PER_ROW=4, BLANK_TICKS=1):
- Reset -> all outputs 0; read addr 5 = 0x00, addr 6 = 0x00; wb_ack pulses exactly 1 cycle per access.
- Write col0=0x01, ctrl=0x03, wait one frame -> row 0 lit cycles show o=0b0000001 and oe=0b0000011; all other rows show only the anode pin driven (oe=o=1<<r); addr 5 reads 0x01.
- Active all-ones frame -> row 3 lit: o=0b0001000, oe=0b1111011 (pin 2 = (3+5+1) mod 7... excluded cathode index 2 is the unused pair); verify oe has exactly 6 bits set for every row and no pin other than r has o=1.
- Write col2=0x7F without setting swap -> active image unchanged over 3 frames; then set bit1 -> change appears in the frame after the next boundary; frame_cnt advanced by 1 per 35 cycles.
- Control write with bit1 landing exactly on the boundary cycle -> no swap that boundary; swap at the following one; pending reads 1 in between.
- Assert rst_n low mid-row and mid-wishbone-read -> outputs 0 asynchronously, no ack; after release the scan restarts at row 0 blank, with the same timing as from power-on.
